biriscv_fetch_flush_ctrl: RTL and testbench

BIRISCV_FETCH_FLUSH_CTRL -- requirements
Module: biriscv_fetch_flush_ctrl

---
 rtl/biriscv_fetch_flush_ctrl.sv | 140 ++++++++++++++
 tb/tb_biriscv_fetch_flush_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_fetch_flush_ctrl.sv
// fence.i sequencer: drains outstanding icache reads, flushes the icache,
// waits for the flush walk (with timeout) and then redirects fetch.
module biriscv_fetch_flush_ctrl #(
    parameter int FLUSH_TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fence_req_i,
    input  logic [31:0] fence_pc_i,
    input  logic [1:0]  fence_priv_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic [1:0]  redirect_priv_i,
    input  logic        fetch_rd_i,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic        icache_flush_done_i,
    output logic        fetch_hold_o,
    output logic        icache_flush_o,
    output logic        branch_request_o,
    output logic [31:0] branch_pc_o,
    output logic [1:0]  branch_priv_o,
    output logic        fence_ack_o,
    output logic        timeout_o,
    output logic        busy_o
);

    localparam logic [1:0]       PRIV_MACHINE = 2'd3;
    localparam int               TMO_W        = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(FLUSH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH,
        ST_WAIT,
        ST_REDIRECT
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       outstanding_q, outstanding_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [31:0]      restart_pc_q, restart_pc_d;
    logic [1:0]       restart_priv_q, restart_priv_d;
    logic             timeout_q, timeout_d;
    logic             rd_accept;
    logic             in_sequence;

    assign rd_accept   = fetch_rd_i && icache_accept_i;
    assign in_sequence = (state_q == ST_DRAIN) || (state_q == ST_FLUSH) || (state_q == ST_WAIT);

    // Outstanding read tracker runs in every state so DRAIN sees an accurate count
    always_comb begin
        outstanding_d = outstanding_q;
        if (rd_accept && !icache_valid_i && (outstanding_q != 2'd3)) begin
            outstanding_d = outstanding_q + 2'd1;
        end else if (!rd_accept && icache_valid_i && (outstanding_q != 2'd0)) begin
            outstanding_d = outstanding_q - 2'd1;
        end
    end

    always_comb begin
        state_d        = state_q;
        tmo_d          = tmo_q;
        restart_pc_d   = restart_pc_q;
        restart_priv_d = restart_priv_q;
        timeout_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fence_req_i) begin
                    state_d        = ST_DRAIN;
                    restart_pc_d   = fence_pc_i;
                    restart_priv_d = fence_priv_i;
                end
            end
            ST_DRAIN: begin
                if ((outstanding_q == 2'd0) && !rd_accept) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (icache_accept_i) begin
                    state_d = ST_WAIT;
                    tmo_d   = '0;
                end
            end
            ST_WAIT: begin
                if (icache_flush_done_i) begin
                    state_d = ST_REDIRECT;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = ST_REDIRECT;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A pipeline redirect mid-sequence supersedes the fence restart target
        if (redirect_i && in_sequence) begin
            restart_pc_d   = redirect_pc_i;
            restart_priv_d = redirect_priv_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            outstanding_q  <= 2'd0;
            tmo_q          <= '0;
            restart_pc_q   <= 32'd0;
            restart_priv_q <= PRIV_MACHINE;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            outstanding_q  <= outstanding_d;
            tmo_q          <= tmo_d;
            restart_pc_q   <= restart_pc_d;
            restart_priv_q <= restart_priv_d;
            timeout_q      <= timeout_d;
        end
    end

    assign busy_o           = (state_q != ST_IDLE);
    assign fetch_hold_o     = in_sequence;
    assign icache_flush_o   = (state_q == ST_FLUSH);
    assign branch_request_o = (state_q == ST_REDIRECT);
    assign fence_ack_o      = (state_q == ST_REDIRECT);
    assign timeout_o        = (state_q == ST_REDIRECT) && timeout_q;
    assign branch_pc_o      = restart_pc_q;
    assign branch_priv_o    = restart_priv_q;

endmodule

// File: tb/tb_biriscv_fetch_flush_ctrl.sv
// Bench for biriscv_fetch_flush_ctrl: directed fence scenarios plus random
// traffic, every cycle compared against a behavioural sequence model.
module tb_biriscv_fetch_flush_ctrl;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fence_req_i;
    logic [31:0] fence_pc_i;
    logic [1:0]  fence_priv_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [1:0]  redirect_priv_i;
    logic        fetch_rd_i;
    logic        icache_accept_i;
    logic        icache_valid_i;
    logic        icache_flush_done_i;
    logic        fetch_hold_o;
    logic        icache_flush_o;
    logic        branch_request_o;
    logic [31:0] branch_pc_o;
    logic [1:0]  branch_priv_o;
    logic        fence_ack_o;
    logic        timeout_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_seen = 0;

    // Model: phase 0 idle, 1 draining, 2 flushing, 3 waiting, 4 redirecting
    int          m_phase  = 0;
    int          m_reads  = 0;
    int          m_waited = 0;
    logic [31:0] m_pc     = 32'd0;
    logic [1:0]  m_priv   = 2'd3;
    bit          m_to     = 1'b0;

    biriscv_fetch_flush_ctrl #(.FLUSH_TIMEOUT(TO)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .fence_req_i         (fence_req_i),
        .fence_pc_i          (fence_pc_i),
        .fence_priv_i        (fence_priv_i),
        .redirect_i          (redirect_i),
        .redirect_pc_i       (redirect_pc_i),
        .redirect_priv_i     (redirect_priv_i),
        .fetch_rd_i          (fetch_rd_i),
        .icache_accept_i     (icache_accept_i),
        .icache_valid_i      (icache_valid_i),
        .icache_flush_done_i (icache_flush_done_i),
        .fetch_hold_o        (fetch_hold_o),
        .icache_flush_o      (icache_flush_o),
        .branch_request_o    (branch_request_o),
        .branch_pc_o         (branch_pc_o),
        .branch_priv_o       (branch_priv_o),
        .fence_ack_o         (fence_ack_o),
        .timeout_o           (timeout_o),
        .busy_o              (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int  nxt;
        bit  acc_rd;
        if (rst_i) begin
            m_phase = 0; m_reads = 0; m_waited = 0;
            m_pc = 32'd0; m_priv = 2'd3; m_to = 1'b0;
            return;
        end
        acc_rd = fetch_rd_i && icache_accept_i;
        nxt    = m_phase;
        m_to   = 1'b0;
        case (m_phase)
            0: if (fence_req_i) begin
                   nxt = 1; m_pc = fence_pc_i; m_priv = fence_priv_i;
               end
            1: if (m_reads == 0 && !acc_rd) nxt = 2;
            2: if (icache_accept_i) begin nxt = 3; m_waited = 0; end
            3: begin
                   m_waited++;
                   if (icache_flush_done_i) nxt = 4;
                   else if (m_waited >= TO) begin nxt = 4; m_to = 1'b1; end
               end
            default: nxt = 0;
        endcase
        if (redirect_i && m_phase >= 1 && m_phase <= 3) begin
            m_pc = redirect_pc_i; m_priv = redirect_priv_i;
        end
        m_reads = m_reads + int'(acc_rd) - int'(icache_valid_i);
        if (m_reads > 3) m_reads = 3;
        if (m_reads < 0) m_reads = 0;
        m_phase = nxt;
    endtask

    task automatic check_outputs();
        chk("busy",    32'(busy_o),           32'(m_phase != 0));
        chk("hold",    32'(fetch_hold_o),     32'(m_phase >= 1 && m_phase <= 3));
        chk("flush",   32'(icache_flush_o),   32'(m_phase == 2));
        chk("br_req",  32'(branch_request_o), 32'(m_phase == 4));
        chk("ack",     32'(fence_ack_o),      32'(m_phase == 4));
        chk("timeout", 32'(timeout_o),        32'(m_phase == 4 && m_to));
        chk("br_pc",   branch_pc_o,           m_pc);
        chk("br_priv", 32'(branch_priv_o),    32'(m_priv));
        if (fence_ack_o) begin
            ack_seen++;
            $display("[TB] t=%0t fence ack pc=%h priv=%0d timeout=%0b",
                     $time, branch_pc_o, branch_priv_o, timeout_o);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic clear_inputs();
        fence_req_i = 0; fence_pc_i = 0; fence_priv_i = 0;
        redirect_i = 0; redirect_pc_i = 0; redirect_priv_i = 0;
        fetch_rd_i = 0; icache_accept_i = 0; icache_valid_i = 0;
        icache_flush_done_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Fence with immediate accept/done; returns cycles until fence_ack_o
    task automatic run_fence(input logic [31:0] pc, output int lat);
        lat = -1;
        icache_accept_i = 1; icache_flush_done_i = 1;
        fence_req_i = 1; fence_pc_i = pc; fence_priv_i = 2'd1;
        tick();
        fence_req_i = 0;
        for (int n = 2; n <= 12; n++) begin
            tick();
            if (fence_ack_o) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat, cnt, waitc, tos, acks0;
        bit flushed;

        rst_i = 1'b1;
        clear_inputs();
        do_reset();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_pc",   branch_pc_o, 32'd0);
        chk("rst_priv", 32'(branch_priv_o), 32'd3);

        // Idle fence, minimum latency
        run_fence(32'h8000_0100, lat);
        chk("idle_lat", 32'(lat), 32'd4);
        chk("idle_pc",  branch_pc_o, 32'h8000_0100);
        chk("idle_br",  32'(branch_request_o), 32'd1);

        // Drain two outstanding reads
        do_reset();
        fetch_rd_i = 1; icache_accept_i = 1;
        tick(); tick();
        fetch_rd_i = 0; icache_flush_done_i = 1;
        fence_req_i = 1; fence_pc_i = 32'h0000_1234;
        tick();
        fence_req_i = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain_hold",  32'(fetch_hold_o),   32'd1);
            chk("drain_flush", 32'(icache_flush_o), 32'd0);
        end
        icache_valid_i = 1;
        tick();
        tick();
        icache_valid_i = 0;
        chk("drain_flush_lo", 32'(icache_flush_o), 32'd0);
        tick();
        chk("drain_flush_hi", 32'(icache_flush_o), 32'd1);
        for (int i = 0; i < 4; i++) tick();

        // Flush back-pressure
        do_reset();
        icache_flush_done_i = 1;
        fence_req_i = 1; fence_pc_i = 32'h0000_4000;
        cnt = 0;
        for (int n = 1; n <= 7; n++) begin
            tick();
            fence_req_i = 0;
            if (icache_flush_o) cnt++;
        end
        icache_accept_i = 1;
        tick();
        if (icache_flush_o) cnt++;
        chk("bp_flush_cycles", 32'(cnt), 32'd6);
        chk("bp_wait_hold",    32'(fetch_hold_o & ~icache_flush_o), 32'd1);
        for (int i = 0; i < 3; i++) tick();

        // Timeout
        do_reset();
        icache_accept_i = 1;
        fence_req_i = 1; fence_pc_i = 32'h0000_0800;
        acks0 = ack_seen; waitc = 0; tos = 0; flushed = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            fence_req_i = 0;
            if (icache_flush_o) flushed = 1;
            else if (flushed && fetch_hold_o) waitc++;
            if (timeout_o) tos++;
        end
        chk("to_pulses", 32'(tos), 32'd1);
        chk("to_wait",   32'(waitc), 32'(TO));
        chk("to_acks",   32'(ack_seen - acks0), 32'd1);

        // Redirect during WAIT, then a fence while busy
        do_reset();
        icache_accept_i = 1;
        fence_req_i = 1; fence_pc_i = 32'h8000_0100;
        acks0 = ack_seen;
        tick(); fence_req_i = 0;
        tick(); tick();
        redirect_i = 1; redirect_pc_i = 32'h0000_2000; redirect_priv_i = 2'd0;
        tick();
        redirect_i = 0;
        fence_req_i = 1; fence_pc_i = 32'hDEAD_BEE0;
        tick();
        fence_req_i = 0; icache_flush_done_i = 1;
        tick();
        chk("redir_ack", 32'(fence_ack_o), 32'd1);
        chk("redir_pc",  branch_pc_o, 32'h0000_2000);
        icache_flush_done_i = 0;
        for (int i = 0; i < 12; i++) tick();
        chk("redir_acks", 32'(ack_seen - acks0), 32'd1);

        // Reset in WAIT aborts the sequence
        do_reset();
        icache_accept_i = 1;
        fence_req_i = 1; fence_pc_i = 32'h0000_3000;
        acks0 = ack_seen;
        tick(); fence_req_i = 0;
        tick(); tick(); tick();
        rst_i = 1;
        tick();
        rst_i = 0;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_hold", 32'(fetch_hold_o), 32'd0);
        chk("abort_pc",   branch_pc_o, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("abort_acks", 32'(ack_seen - acks0), 32'd0);
        run_fence(32'h0000_5000, lat);
        chk("post_abort_lat", 32'(lat), 32'd4);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst_i               = ($urandom_range(0, 199) == 0);
            fence_req_i         = ($urandom_range(0, 9) == 0);
            fence_pc_i          = $urandom;
            fence_priv_i        = 2'($urandom_range(0, 3));
            redirect_i          = ($urandom_range(0, 9) == 0);
            redirect_pc_i       = $urandom;
            redirect_priv_i     = 2'($urandom_range(0, 3));
            fetch_rd_i          = ($urandom_range(0, 1) == 0);
            icache_accept_i     = ($urandom_range(0, 9) < 6);
            icache_valid_i      = ($urandom_range(0, 9) < 3);
            icache_flush_done_i = ($urandom_range(0, 9) < 2);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
